// File: rtl/srl_fifo_ctrl.sv
// First-word-fall-through FIFO over a 32-deep shift-register store.
// Writes shift in at index 0; the head is read through the tap at COUNT-1.
module srl_fifo_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [5:0]       COUNT,
  output logic             ALMOST_FULL
);

  localparam logic [5:0] DEPTH    = 6'd32;
  localparam logic [5:0] AF_LEVEL = 6'(AFULL_THRESH);

  logic [WIDTH-1:0] srl_q [32];
  logic [5:0]       count_q, count_d;
  logic [4:0]       rd_addr;
  logic             push, pop;

  assign I_READY = RST_N & ~FLUSH & (count_q != DEPTH);
  assign O_VALID = RST_N & (count_q != 6'd0);
  assign push    = I_VALID & I_READY;
  assign pop     = O_VALID & O_READY;

  // Tap only meaningful when non-empty; O_DATA is forced to zero otherwise.
  assign rd_addr     = 5'(count_q - 6'd1);
  assign O_DATA      = O_VALID ? srl_q[rd_addr] : '0;
  assign ALMOST_FULL = RST_N & (count_q >= AF_LEVEL);
  assign COUNT       = count_q;

  always_comb begin
    count_d = count_q;
    if (FLUSH) begin
      count_d = 6'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage has no reset path so it maps onto plain shift-register primitives.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int i = 31; i > 0; i--) begin
        srl_q[i] <= srl_q[i-1];
      end
      srl_q[0] <= I_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert (count_q <= DEPTH)
        else $error("srl_fifo_ctrl occupancy above depth: %0d", count_q);
    end
  end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: directed scenarios plus random traffic, all compared
// every cycle against a queue-based FIFO model.
module tb_srl_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       FLUSH = 1'b0;
  logic [7:0] I_DATA = '0;
  logic       I_VALID = 1'b0;
  logic       I_READY;
  logic [7:0] O_DATA;
  logic       O_VALID;
  logic       O_READY = 1'b0;
  logic [5:0] COUNT;
  logic       ALMOST_FULL;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q[$];

  srl_fifo_ctrl #(.WIDTH(8), .AFULL_THRESH(28)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .I_DATA(I_DATA), .I_VALID(I_VALID), .I_READY(I_READY),
    .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
    .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, compare outputs against the model at the falling
  // edge, then advance the model with the FIFO rules at the rising edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [7:0] d, input logic ordy);
    int  sz;
    bit  do_push, do_pop;
    RST_N = rst; FLUSH = fl; I_VALID = iv; I_DATA = d; O_READY = ordy;
    @(negedge CLK);
    sz = q.size();
    check("count",   COUNT,       sz);
    check("i_ready", I_READY,     (rst && !fl && sz != 32) ? 1 : 0);
    check("o_valid", O_VALID,     (rst && sz > 0) ? 1 : 0);
    check("o_data",  O_DATA,      (rst && sz > 0) ? q[0] : 8'h00);
    check("afull",   ALMOST_FULL, (rst && sz >= 28) ? 1 : 0);
    do_pop  = rst && sz > 0 && ordy;
    do_push = rst && !fl && iv && sz < 32;
    @(posedge CLK);
    if (!rst || fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    #1;
  endtask

  initial begin
    bit bias_full;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held with a write attempt present
    cycle(0, 0, 1, 8'h5A, 0);
    cycle(0, 0, 1, 8'h5A, 0);
    check("rst_count", COUNT, 0);
    cycle(1, 0, 0, 8'h00, 0);
    check("rel_count", COUNT, 0);

    // Fill 0x01..0x20, then a refused 33rd write
    for (int i = 1; i <= 32; i++) begin
      cycle(1, 0, 1, 8'(i), 0);
      check("fill_count", COUNT, i);
      check("fill_afull", ALMOST_FULL, (i >= 28) ? 1 : 0);
    end
    check("full_ready", I_READY, 0);
    cycle(1, 0, 1, 8'h21, 0);
    check("no_33rd", COUNT, 32);
    for (int i = 1; i <= 32; i++) begin
      check("drain_order", O_DATA, i);
      cycle(1, 0, 0, 8'h00, 1);
    end
    check("drained_valid", O_VALID, 0);

    // Simultaneous push/pop at 31
    for (int i = 1; i <= 31; i++) cycle(1, 0, 1, 8'(i), 0);
    check("sim_head", O_DATA, 8'h01);
    cycle(1, 0, 1, 8'hAA, 1);
    check("sim_count", COUNT, 31);
    for (int i = 2; i <= 31; i++) begin
      check("sim_order", O_DATA, i);
      cycle(1, 0, 0, 8'h00, 1);
    end
    check("sim_last", O_DATA, 8'hAA);
    cycle(1, 0, 0, 8'h00, 1);

    // Streaming from empty
    check("stream_empty", O_VALID, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 1, 8'(8'h10 + i), 1);
      check("stream_count", COUNT, 1);
      check("stream_head", O_DATA, 8'h10 + i);
    end
    cycle(1, 0, 0, 8'h00, 1);

    // Flush at COUNT=10 with a write attempt
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 8'(8'h40 + i), 0);
    cycle(1, 1, 1, 8'h77, 0);
    check("flush_count", COUNT, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 1);

    // Reset pulse mid-run at COUNT=17
    for (int i = 0; i < 17; i++) cycle(1, 0, 1, 8'(8'h80 + i), 0);
    cycle(0, 0, 0, 8'h00, 0);
    check("mid_rst_count", COUNT, 0);
    check("mid_rst_data", O_DATA, 8'h00);
    cycle(1, 0, 1, 8'h3C, 0);
    check("post_rst_head", O_DATA, 8'h3C);
    cycle(1, 0, 0, 8'h00, 1);
    check("post_rst_empty", O_VALID, 0);

    // Random traffic with alternating fill/drain bias to reach both ends
    bias_full = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 80 == 0) bias_full = ~bias_full;
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 59) == 0),
            bias_full ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
            8'($urandom),
            bias_full ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
